// File: rtl/f_mult_share_arb_if.sv
// Bus bundle between the requesters, the shared-multiplier arbiter and f_mult.
// slave: the arbiter's view; master: the requester/multiplier side (testbench).
interface f_mult_share_arb_if #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned FLEN  = 64
);
  // Requester side
  logic [N_REQ-1:0]      req_vld;
  logic [N_REQ*FLEN-1:0] req_a;
  logic [N_REQ*FLEN-1:0] req_b;
  logic [N_REQ-1:0]      req_rdy;
  logic [N_REQ-1:0]      rsp_vld;
  logic [FLEN-1:0]       rsp_res;
  logic                  rsp_err;
  // Multiplier side
  logic [FLEN-1:0]       mult_a;
  logic [FLEN-1:0]       mult_b;
  logic                  mult_up_valid;
  logic [FLEN-1:0]       mult_res;
  logic                  mult_down_valid;
  logic                  mult_error;
  // Status
  logic                  busy;
  logic                  proto_err;
  logic [7:0]            err_cnt;

  modport slave (
    input  req_vld, req_a, req_b, mult_res, mult_down_valid, mult_error,
    output req_rdy, rsp_vld, rsp_res, rsp_err, mult_a, mult_b, mult_up_valid,
           busy, proto_err, err_cnt
  );

  modport master (
    output req_vld, req_a, req_b, mult_res, mult_down_valid, mult_error,
    input  req_rdy, rsp_vld, rsp_res, rsp_err, mult_a, mult_b, mult_up_valid,
           busy, proto_err, err_cnt
  );
endinterface

// File: rtl/f_mult_share_arb.sv
// Round-robin arbiter sharing one in-order pipelined f_mult between N_REQ
// requesters. A tag FIFO records the owner of each in-flight multiply so that
// results are routed back to the issuing requester in issue order.
// Optional feature: define F_MULT_ARB_ERR_CNT_EN to enable the saturating
// error counter on err_cnt; otherwise err_cnt is tied to zero.
module f_mult_share_arb #(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned FLEN         = 64
) (
  input  logic             clk,
  input  logic             rst,
  f_mult_share_arb_if.slave bus
);

  localparam int unsigned TAG_W = $clog2(N_REQ);
  localparam int unsigned PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int unsigned DEPTH = 2 ** PTR_W;
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT) + 1;

  // Requester index base+k wrapped into 0..N_REQ-1 (N_REQ need not be a power of 2).
  function automatic logic [TAG_W-1:0] rr_idx(input logic [TAG_W-1:0] base,
                                              input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return TAG_W'(s);
  endfunction

  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0] tag_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_d [DEPTH];
  logic [N_REQ-1:0] rsp_vld_q, rsp_vld_d;
  logic [FLEN-1:0]  rsp_res_q, rsp_res_d;
  logic             rsp_err_q, rsp_err_d;
  logic             proto_err_q, proto_err_d;

  logic             can_issue;
  logic             found;
  logic [TAG_W-1:0] sel_idx;
  logic             grant_vld;
  logic             push;
  logic             pop;
  logic             stray;
  logic             res_err;

  // Round-robin search from rr_ptr, gated by the in-flight limit.
  always_comb begin
    found     = 1'b0;
    sel_idx   = '0;
    can_issue = (cnt_q < CNT_W'(MAX_INFLIGHT)) || bus.mult_down_valid;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && bus.req_vld[rr_idx(rr_ptr_q, k)]) begin
        found   = 1'b1;
        sel_idx = rr_idx(rr_ptr_q, k);
      end
    end
    grant_vld = found && can_issue;
  end

  // Combinational grant and operand mux toward f_mult.
  always_comb begin
    bus.req_rdy       = '0;
    if (grant_vld) bus.req_rdy = N_REQ'(1) << sel_idx;
    bus.mult_up_valid = grant_vld;
    bus.mult_a        = bus.req_a[32'(sel_idx) * FLEN +: FLEN];
    bus.mult_b        = bus.req_b[32'(sel_idx) * FLEN +: FLEN];
  end

  // Tag FIFO bookkeeping, response capture and pointer updates.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    tag_mem_d   = tag_mem_q;
    rsp_vld_d   = '0;
    rsp_res_d   = rsp_res_q;
    rsp_err_d   = rsp_err_q;
    proto_err_d = proto_err_q;

    push    = grant_vld;
    pop     = bus.mult_down_valid && (cnt_q != '0);
    stray   = bus.mult_down_valid && (cnt_q == '0);
    res_err = (bus.mult_error === 1'b1);

    if (push) begin
      tag_mem_d[wr_ptr_q] = sel_idx;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      rr_ptr_d            = rr_idx(sel_idx, 1);
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      rsp_vld_d = N_REQ'(1) << tag_mem_q[rd_ptr_q];
      rsp_res_d = bus.mult_res;
      rsp_err_d = res_err;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // A result with nothing outstanding is a protocol violation; sticky.
    if (stray) proto_err_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_vld_q   <= '0;
      rsp_res_q   <= '0;
      rsp_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) tag_mem_q[i] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_res_q   <= rsp_res_d;
      rsp_err_q   <= rsp_err_d;
      proto_err_q <= proto_err_d;
      tag_mem_q   <= tag_mem_d;
    end
  end

`ifdef F_MULT_ARB_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of results returned with the error flag set.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (pop && res_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= 8'd0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = 8'd0;
`endif

  assign bus.rsp_vld   = rsp_vld_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.proto_err = proto_err_q;
  assign bus.busy      = (cnt_q != '0);

endmodule

// File: tb/tb_f_mult_share_arb.sv
// Bench for f_mult_share_arb: a fixed-latency double-precision multiplier model,
// directed scenarios followed by random traffic, and a scoreboard that predicts
// grants and routed results from the arbitration rules.
module tb_f_mult_share_arb;
  localparam int N    = 2;
  localparam int FL   = 64;
  localparam int MAXF = 4;
  localparam int LAT  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_dv = 1'b0;

  always #5 clk = ~clk;

  f_mult_share_arb_if #(.N_REQ(N), .FLEN(FL)) ifc ();

  f_mult_share_arb #(.N_REQ(N), .MAX_INFLIGHT(MAXF), .FLEN(FL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          tag;
    logic [63:0] res;
    bit          err;
  } exp_t;

  exp_t tag_q[$];
  exp_t rsp_q[$];
  int   rr_m;
  bit   proto_m;
  int   err_m;

  function automatic logic [63:0] mul_bits(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  function automatic bit is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Pipelined multiplier model; the error flag marks a NaN product.
  logic        pv [LAT];
  logic [63:0] pr [LAT];
  logic        pe [LAT];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pv[i] <= 1'b0; pr[i] <= '0; pe[i] <= 1'b0;
      end
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] <= pv[i-1]; pr[i] <= pr[i-1]; pe[i] <= pe[i-1];
      end
      pv[0] <= ifc.mult_up_valid;
      pr[0] <= mul_bits(ifc.mult_a, ifc.mult_b);
      pe[0] <= is_nan(mul_bits(ifc.mult_a, ifc.mult_b));
    end
  end

  assign ifc.mult_down_valid = pv[LAT-1] | force_dv;
  assign ifc.mult_res        = force_dv ? 64'h0 : pr[LAT-1];
  assign ifc.mult_error      = force_dv ? 1'b0 : pe[LAT-1];

  // Scoreboard: predicts grants from round-robin rules and routes results by owner.
  always @(negedge clk) begin : monitor
    int   g;
    int   idx;
    bit   dv;
    bit   can;
    exp_t e;
    if (rst) begin
      tag_q.delete();
      rsp_q.delete();
      rr_m    = 0;
      proto_m = 1'b0;
      err_m   = 0;
    end else begin
      if (ifc.rsp_vld != '0) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_vld_unexpected", 64'(ifc.rsp_vld), 64'd0);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_vld_owner", 64'(ifc.rsp_vld), 64'(1) << e.tag);
          chk("rsp_res", ifc.rsp_res, e.res);
          chk("rsp_err", 64'(ifc.rsp_err), 64'(e.err));
          if (e.err && err_m < 255) err_m++;
        end
      end else if (rsp_q.size() != 0) begin
        e = rsp_q.pop_front();
        chk("rsp_vld_missing", 64'(ifc.rsp_vld), 64'(1) << e.tag);
      end
`ifdef F_MULT_ARB_ERR_CNT_EN
      chk("err_cnt", 64'(ifc.err_cnt), 64'(err_m));
`else
      chk("err_cnt", 64'(ifc.err_cnt), 64'd0);
`endif
      chk("busy", 64'(ifc.busy), 64'(tag_q.size() != 0));
      chk("proto_err", 64'(ifc.proto_err), 64'(proto_m));

      dv  = ifc.mult_down_valid;
      can = (tag_q.size() < MAXF) || dv;
      g   = -1;
      if (can) begin
        for (int k = 0; k < N; k++) begin
          idx = (rr_m + k) % N;
          if (g < 0 && ifc.req_vld[idx]) g = idx;
        end
      end
      chk("req_rdy", 64'(ifc.req_rdy), (g >= 0) ? (64'(1) << g) : 64'd0);
      chk("mult_up_valid", 64'(ifc.mult_up_valid), 64'(g >= 0));

      if (dv) begin
        if (tag_q.size() > 0) rsp_q.push_back(tag_q.pop_front());
        else proto_m = 1'b1;
      end
      if (g >= 0) begin
        chk("mult_a", ifc.mult_a, ifc.req_a[g*FL +: FL]);
        chk("mult_b", ifc.mult_b, ifc.req_b[g*FL +: FL]);
        e.tag = g;
        e.res = mul_bits(ifc.req_a[g*FL +: FL], ifc.req_b[g*FL +: FL]);
        e.err = is_nan(e.res);
        tag_q.push_back(e);
        rr_m = (g + 1) % N;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input real a, input real b);
    ifc.req_vld[i]          = v;
    ifc.req_a[i*FL +: FL]   = $realtobits(a);
    ifc.req_b[i*FL +: FL]   = $realtobits(b);
  endtask

  task automatic check_reset_vals();
    chk("rst_rsp_vld", 64'(ifc.rsp_vld), 64'd0);
    chk("rst_rsp_res", ifc.rsp_res, 64'd0);
    chk("rst_rsp_err", 64'(ifc.rsp_err), 64'd0);
    chk("rst_proto_err", 64'(ifc.proto_err), 64'd0);
    chk("rst_err_cnt", 64'(ifc.err_cnt), 64'd0);
    chk("rst_busy", 64'(ifc.busy), 64'd0);
    chk("rst_req_rdy", 64'(ifc.req_rdy), 64'd0);
  endtask

  // Asynchronous reset pulse with immediate output checks.
  task automatic do_reset();
    ifc.req_vld = '0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals();
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (ifc.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      failures++;
      $display("FAIL drain_timeout actual=busy expected=idle within 200 cycles");
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic real rand_op();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 3) return $bitstoreal(64'h7FF0000000000000);
    if (r < 9) return 0.0;
    return real'(int'($urandom_range(0, 64)) - 32) * 0.125;
  endfunction

  initial begin
    logic [N-1:0] acc;
    real inf_v;
    inf_v       = $bitstoreal(64'h7FF0000000000000);
    ifc.req_vld = '0;
    ifc.req_a   = '0;
    ifc.req_b   = '0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    next_cycle();
    rst = 1'b0;

    // Single request: 2.0*3.0 from requester 0.
    next_cycle();
    set_req(0, 1'b1, 2.0, 3.0);
    next_cycle();
    set_req(0, 1'b0, 0.0, 0.0);
    wait_idle();

    // Contention from reset: alternate grants.
    do_reset();
    set_req(0, 1'b1, 1.5, 2.0);
    set_req(1, 1'b1, -1.0, 4.0);
    repeat (4) next_cycle();
    ifc.req_vld = '0;
    wait_idle();

    // Full FIFO: continuous requests from requester 0.
    set_req(0, 1'b1, 2.0, 0.5);
    repeat (12) next_cycle();
    ifc.req_vld = '0;
    wait_idle();

    // Error path: Inf*0 from requester 1.
    set_req(1, 1'b1, inf_v, 0.0);
    next_cycle();
    ifc.req_vld = '0;
    wait_idle();

    // Stray result while idle.
    force_dv = 1'b1;
    next_cycle();
    force_dv = 1'b0;
    repeat (3) next_cycle();

    // Reset with three operations in flight; next grant must go to requester 0.
    set_req(0, 1'b1, 3.0, 3.0);
    repeat (3) next_cycle();
    ifc.req_vld = '0;
    next_cycle();
    do_reset();
    set_req(0, 1'b1, 1.0, 5.0);
    set_req(1, 1'b1, 2.0, 5.0);
    next_cycle();
    ifc.req_vld = '0;
    wait_idle();

    // Random traffic; operands held until accepted.
    repeat (400) begin
      @(negedge clk);
      acc = ifc.req_vld & ifc.req_rdy;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!ifc.req_vld[i] || acc[i]) begin
          if ($urandom_range(0, 9) < 6) set_req(i, 1'b1, rand_op(), rand_op());
          else ifc.req_vld[i] = 1'b0;
        end
      end
    end
    next_cycle();
    ifc.req_vld = '0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/f_mult_share_arb.md
# f_mult_share_arb

Round-robin arbiter and sequencer that shares one pipelined `f_mult` instance between `N_REQ` independent floating-point requesters. It sits between client FSMs and the multiplier, issues at most one multiplication per cycle, and tracks the owner of every in-flight operation in a tag FIFO. It returns each result, in order, to the requester that issued it. The multiplier's own `busy` output is not used; issue throttling is done by the in-flight count.

## Interface
- `N_REQ`, default 2: number of requesters, range 2..8.
- `MAX_INFLIGHT`, default 4: tag FIFO depth and in-flight limit; must be a power of 2.
- `FLEN`: operand width, taken from the shared cvw config; not overridden here.
- `clk`  in  1  clock; one clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_vld`  in  N_REQ  per-requester request valid.
- `req_a`, `req_b`  in  N_REQ*FLEN each  operands; requester i occupies bits [i*FLEN +: FLEN].
- `req_rdy`  out  N_REQ  one-hot grant; the request is accepted when `req_vld[i] && req_rdy[i]`.
- `rsp_vld`  out  N_REQ  one-hot result strobe, 1 cycle wide, with no backpressure.
- `rsp_res`  out  FLEN  result, broadcast to all requesters; meaningful only while any `rsp_vld` is high.
- `rsp_err`  out  1  error flag of the returned result.
- `mult_a`, `mult_b`  out  FLEN  operands to `f_mult`.
- `mult_up_valid`  out  1  issue strobe to `f_mult`.
- `mult_res`  in  FLEN  result from `f_mult`.
- `mult_down_valid`  in  1  result valid from `f_mult`.
- `mult_error`  in  1  error flag from `f_mult`.
- `busy`  out  1  high while any operation is in flight.
- `proto_err`  out  1  sticky flag: a result arrived with no tag outstanding.
- `err_cnt`  out  8  saturating error count; see Configuration.

## Operation
- Issue condition: `can_issue = (cnt < MAX_INFLIGHT) || mult_down_valid`.
- Grant: combinational round-robin. Search starts at `rr_ptr` and selects the first i with `req_vld[i]`. Gated by `can_issue`.
- No grant (no valid requester or `!can_issue`) drives `req_rdy` to 0 and `mult_up_valid` to 0.
- `mult_a`/`mult_b` mux the granted requester's operands combinationally; they are don't-care when no grant.
- `mult_up_valid = |req_rdy`.
- On a grant to requester g:
  - `rr_ptr <= (g+1) mod N_REQ`.
  - The tag g is pushed into the FIFO.
  - Without a grant, `rr_ptr` holds.
- Tag FIFO: `$clog2(N_REQ)`-bit entries with `MAX_INFLIGHT` entries. Read pointer, write pointer and `cnt` wrap naturally.
  - Push only: cnt+1.
  - Pop only: cnt-1.
  - Push and pop in the same cycle: cnt unchanged.
  - A push at cnt==MAX_INFLIGHT with a simultaneous pop is legal.
- On `mult_down_valid` with cnt>0:
  - The head tag t is popped.
  - Registered outputs: `rsp_vld <= 1<<t`, `rsp_res <= mult_res`, `rsp_err <= mult_error === 1'b1`.
- On `mult_down_valid` with cnt==0:
  - No pop, and `rsp_vld` stays 0.
  - `proto_err <= 1`, which holds until reset.
- `busy = (cnt != 0)`.
- Results return strictly in issue order; the arbiter relies on `f_mult` being in-order.

## Timing
- Issue: same cycle. `req_rdy`/`mult_up_valid` are combinational from `req_vld`, `cnt` and `rr_ptr`.
- Response: `rsp_vld` rises exactly 1 cycle after `mult_down_valid`.
- End-to-end latency: the `f_mult` latency + 1.
- Throughput: 1 issue and 1 return per cycle.
- Reset values:
  - Outputs: `rsp_vld`=0, `rsp_res`=0, `rsp_err`=0, `proto_err`=0, `err_cnt`=0, `busy`=0.
  - Internal state: `req_rdy`=0 (no requests), `cnt`=0, pointers=0, `rr_ptr`=0.
- Reset mid-operation: all tags are discarded. `f_mult` shares `rst`, so no stale results are expected; any that do arrive set `proto_err`.
- A requester may hold `req_vld` for several cycles. Its operands must stay stable until `req_rdy` is seen.

## Configuration
- `F_MULT_ARB_ERR_CNT_EN` defined:
  - `err_cnt` counts returned results with `rsp_err`=1.
  - It increments in the same cycle `rsp_err` is registered high and saturates at 255.
  - Cleared only by `rst`.
- Undefined: `err_cnt` is tied to 8'd0 and the counter logic is absent.

## Test plan
- Single requester, N_REQ=2: requester 0 issues 2.0*3.0.
  - Same cycle: `req_rdy`=2'b01 and `mult_up_valid`=1.
  - One cycle after `mult_down_valid`: `rsp_vld`=2'b01, `rsp_res`=6.0, `rsp_err`=0.
- Contention: both `req_vld` held high for 4 cycles from reset.
  - Grants alternate 01,10,01,10.
  - Responses return in the same order with the correct products (1.5*2.0=3.0 for req 0, -1.0*4.0=-4.0 for req 1).
- Full FIFO, MAX_INFLIGHT=4: requester 0 issues continuously.
  - `req_rdy` drops after 4 issues until the first `mult_down_valid`.
  - On that cycle a 5th issue is accepted together with the pop, and cnt stays 4.
- Error path: Inf*0.0 from requester 1.
  - Response: `rsp_vld`=2'b10, `rsp_err`=1.
  - With `F_MULT_ARB_ERR_CNT_EN`, `err_cnt`=1; without it, `err_cnt`=0.
- Protocol: force `mult_down_valid`=1 while idle.
  - Response: `rsp_vld` stays 0 and `proto_err`=1 until `rst`.
- Reset mid-flight: assert `rst` with 3 operations in flight.
  - All outputs return to their reset values immediately (asynchronously).
  - `busy`=0, and the next grant goes to requester 0.
